array_pingpong_demux: RTL and testbench

- Inverse of the 4-word array 2:1 select path: takes one stream of 4-element word arrays and steers each array to one of two destination ports (bank 0 / bank 1).
- Each destination port is registered with a one-entry output buffer and a valid/ready handshake.
- Feeds the two ping-pong operand banks of the datapath.
- Steering is either automatic alternation (ping-pong) or an explicit per-transfer select.

---
 rtl/array_pingpong_demux.sv | 89 ++++++++
 tb/tb_array_pingpong_demux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_pingpong_demux.sv
// Steers a stream of 4-element word arrays to one of two registered output
// banks, either by ping-pong alternation or by an explicit per-transfer select.
module array_pingpong_demux #(
  parameter int unsigned bits  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0][bits-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic                 sel_dest,
  output logic [3:0][bits-1:0] out0_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [3:0][bits-1:0] out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic                 next_dest,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

  bank_state_t state0, state1;
  logic        target;
  logic        accept;
  logic        acc0, acc1;
  logic        xfer0, xfer1;

  assign out0_valid = (state0 == FULL);
  assign out1_valid = (state1 == FULL);

  // in_ready only looks at the targeted bank, so a stalled bank never blocks
  // traffic aimed at the other one.
  always_comb begin
    target   = mode ? sel_dest : next_dest;
    xfer0    = out0_valid && out0_ready;
    xfer1    = out1_valid && out1_ready;
    in_ready = target ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    accept   = in_valid && in_ready;
    acc0     = accept && !target;
    acc1     = accept && target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0    <= EMPTY;
      out0_data <= '0;
      cnt0      <= '0;
    end else begin
      case (state0)
        EMPTY: if (acc0) state0 <= FULL;
        FULL:  if (xfer0 && !acc0) state0 <= EMPTY;
        default: state0 <= EMPTY;
      endcase
      if (acc0)  out0_data <= in_data;
      if (xfer0) cnt0      <= cnt0 + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state1    <= EMPTY;
      out1_data <= '0;
      cnt1      <= '0;
    end else begin
      case (state1)
        EMPTY: if (acc1) state1 <= FULL;
        FULL:  if (xfer1 && !acc1) state1 <= EMPTY;
        default: state1 <= EMPTY;
      endcase
      if (acc1)  out1_data <= in_data;
      if (xfer1) cnt1      <= cnt1 + 1'b1;
    end
  end

  // The pointer advances only on alternate-mode accepts; explicit transfers
  // leave it where it was so alternation resumes seamlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      next_dest <= 1'b0;
    else if (accept && !mode)
      next_dest <= !next_dest;
  end

endmodule

// File: tb/tb_array_pingpong_demux.sv
// Randomized and directed bench for array_pingpong_demux, checked against a
// per-bank occupancy model driven by the handshake rules.
module tb_array_pingpong_demux;

  localparam int unsigned BITS = 8;
  localparam int unsigned CW   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0][BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic                 sel_dest;
  logic [3:0][BITS-1:0] out0_data;
  logic                 out0_valid;
  logic                 out0_ready;
  logic [3:0][BITS-1:0] out1_data;
  logic                 out1_valid;
  logic                 out1_ready;
  logic                 next_dest;
  logic [CW-1:0]        cnt0;
  logic [CW-1:0]        cnt1;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit                   m_full[2];
  logic [3:0][BITS-1:0] m_data[2];
  int                   m_cnt[2];
  bit                   m_ptr;

  array_pingpong_demux #(.bits(BITS), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .sel_dest   (sel_dest),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .next_dest  (next_dest),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 1'b0;
      m_data[b] = '0;
      m_cnt[b]  = 0;
    end
    m_ptr = 1'b0;
  endtask

  task automatic check_outputs();
    check("out0_valid", 32'(out0_valid), 32'(m_full[0]));
    check("out1_valid", 32'(out1_valid), 32'(m_full[1]));
    check("out0_data",  out0_data, m_data[0]);
    check("out1_data",  out1_data, m_data[1]);
    check("next_dest",  32'(next_dest), 32'(m_ptr));
    check("cnt0",       32'(cnt0), 32'(m_cnt[0] % (1 << CW)));
    check("cnt1",       32'(cnt1), 32'(m_cnt[1] % (1 << CW)));
  endtask

  // Called with inputs already set; returns 1 time unit after the edge.
  task automatic cycle();
    int  t;
    bit  rdy[2];
    bit  exp_rdy;
    bit  acc;
    t = mode ? int'(sel_dest) : int'(m_ptr);
    rdy[0] = out0_ready;
    rdy[1] = out1_ready;
    exp_rdy = !m_full[t] || rdy[t];
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (m_full[b] && rdy[b]) begin
        m_full[b] = 1'b0;
        m_cnt[b]++;
      end
    end
    if (acc) begin
      m_full[t] = 1'b1;
      m_data[t] = in_data;
      if (!mode) m_ptr = !m_ptr;
    end
    #1;
    check_outputs();
  endtask

  task automatic send(input bit m, input bit s, input logic [31:0] d);
    in_valid = 1'b1;
    mode     = m;
    sel_dest = s;
    in_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; sel_dest = 1'b0;
    in_data = '0; out0_ready = 1'b1; out1_ready = 1'b1;
    model_reset();

    // reset then alternate streaming
    apply_reset();
    send(1'b0, 1'b0, 32'h01020304);
    check("t1_ptr_a", 32'(next_dest), 32'd1);
    check("t1_bank0_a", out0_data, 32'h01020304);
    send(1'b0, 1'b0, 32'h05060708);
    check("t1_ptr_b", 32'(next_dest), 32'd0);
    check("t1_bank1_b", out1_data, 32'h05060708);
    send(1'b0, 1'b0, 32'h090a0b0c);
    check("t1_ptr_c", 32'(next_dest), 32'd1);
    check("t1_bank0_c", out0_data, 32'h090a0b0c);
    idle(1);
    check("t1_cnt0", 32'(cnt0), 32'd2);
    check("t1_cnt1", 32'(cnt1), 32'd1);

    // backpressure on bank 0
    apply_reset();
    out0_ready = 1'b0;
    send(1'b0, 1'b0, 32'hAAAA0001);
    send(1'b0, 1'b0, 32'hBBBB0002);
    send(1'b0, 1'b0, 32'hCCCC0003);
    check("t2_stall_ready", 32'(in_ready), 32'd0);
    cycle();
    check("t2_hold_a", out0_data, 32'hAAAA0001);
    check("t2_cnt1", 32'(cnt1), 32'd1);
    out0_ready = 1'b1;
    #1;
    check("t2_ready_up", 32'(in_ready), 32'd1);
    cycle();
    check("t2_bank0_c", out0_data, 32'hCCCC0003);
    check("t2_valid_held", 32'(out0_valid), 32'd1);
    idle(2);

    // explicit select
    apply_reset();
    send(1'b1, 1'b1, 32'h11111111);
    check("t3_b1_1", out1_data, 32'h11111111);
    send(1'b1, 1'b1, 32'h22222222);
    check("t3_b1_2", out1_data, 32'h22222222);
    send(1'b1, 1'b0, 32'h33333333);
    check("t3_b0_3", out0_data, 32'h33333333);
    send(1'b1, 1'b1, 32'h44444444);
    check("t3_b1_4", out1_data, 32'h44444444);
    check("t3_ptr", 32'(next_dest), 32'd0);
    send(1'b0, 1'b1, 32'h55555555);
    check("t3_alt_b0", out0_data, 32'h55555555);
    idle(2);

    // extreme values and element order
    send(1'b1, 1'b0, 32'hFF00A55A);
    begin
      logic [3:0][BITS-1:0] v;
      v = out0_data;
      check("t6_elem3", 32'(v[3]), 32'hFF);
      check("t6_elem2", 32'(v[2]), 32'h00);
      check("t6_elem1", 32'(v[1]), 32'hA5);
      check("t6_elem0", 32'(v[0]), 32'h5A);
    end
    idle(1);

    // async reset with both banks full and stalled
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(1'b0, 1'b0, 32'hDEAD0000);
    send(1'b0, 1'b0, 32'hBEEF1111);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_v0", 32'(out0_valid), 32'd0);
    check("t4_v1", 32'(out1_valid), 32'd0);
    check("t4_cnt0", 32'(cnt0), 32'd0);
    check("t4_cnt1", 32'(cnt1), 32'd0);
    check("t4_ptr", 32'(next_dest), 32'd0);
    model_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // counter wrap on bank 1
    apply_reset();
    for (int i = 0; i < 17; i++) send(1'b1, 1'b1, $urandom);
    idle(1);
    check("t5_cnt1_wrap", 32'(cnt1), 32'd1);
    check("t5_cnt0", 32'(cnt0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      mode       = $urandom_range(0, 1);
      sel_dest   = $urandom_range(0, 1);
      in_data    = $urandom;
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      #1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
